// File: rtl/wb_rf_arbiter_if.sv
// Request/response bundle between the ALU/cache writeback stages and the RF write-port arbiter.
// master = requesters + flush source; slave = arbiter.
interface wb_rf_arbiter_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int PC_W    = 32,
  parameter int XADDR_W = 32
);
  logic               alu_valid;
  logic               alu_ready;
  logic               alu_write_rf;
  logic [ADDR_W-1:0]  alu_dest;
  logic [DATA_W-1:0]  alu_data;
  logic               alu_xcpt;
  logic [PC_W-1:0]    alu_pc;
  logic [XADDR_W-1:0] alu_xcpt_addr;

  logic               cache_valid;
  logic               cache_ready;
  logic               cache_write_rf;
  logic [ADDR_W-1:0]  cache_dest;
  logic [DATA_W-1:0]  cache_data;
  logic               cache_xcpt;
  logic [PC_W-1:0]    cache_pc;
  logic [XADDR_W-1:0] cache_xcpt_addr;

  logic               flush;

  logic               req_to_RF_writeEn;
  logic [ADDR_W-1:0]  req_to_RF_dest;
  logic [DATA_W-1:0]  req_to_RF_data;
  logic               xcpt_valid;
  logic [PC_W-1:0]    rmPC;
  logic [XADDR_W-1:0] rmAddr;
  logic               xcpt_hold;

  modport master (
    output alu_valid, alu_write_rf, alu_dest, alu_data, alu_xcpt, alu_pc, alu_xcpt_addr,
    output cache_valid, cache_write_rf, cache_dest, cache_data, cache_xcpt, cache_pc,
           cache_xcpt_addr,
    output flush,
    input  alu_ready, cache_ready,
    input  req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data, xcpt_valid, rmPC, rmAddr,
           xcpt_hold
  );

  modport slave (
    input  alu_valid, alu_write_rf, alu_dest, alu_data, alu_xcpt, alu_pc, alu_xcpt_addr,
    input  cache_valid, cache_write_rf, cache_dest, cache_data, cache_xcpt, cache_pc,
           cache_xcpt_addr,
    input  flush,
    output alu_ready, cache_ready,
    output req_to_RF_writeEn, req_to_RF_dest, req_to_RF_data, xcpt_valid, rmPC, rmAddr,
           xcpt_hold
  );
endinterface

// File: rtl/wb_rf_arbiter.sv
// Writeback arbiter: round-robin share of the RF write port between ALU and cache stages,
// registering the winner and reporting exceptions, then holding until flush.
module wb_rf_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int PC_W    = 32,
  parameter int XADDR_W = 32
) (
  input logic             clock,
  input logic             reset,
  wb_rf_arbiter_if.slave  bus
);
  typedef enum logic {RUN, HOLD} state_e;
  typedef enum logic {RR_ALU, RR_CACHE} rr_e;

  state_e state_q, state_d;
  rr_e    rr_q, rr_d;

  logic               we_q, we_d;
  logic [ADDR_W-1:0]  dest_q, dest_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               xv_q, xv_d;
  logic [PC_W-1:0]    rmpc_q, rmpc_d;
  logic [XADDR_W-1:0] rmaddr_q, rmaddr_d;

  logic               grant_alu, grant_cache, accept;
  logic               sel_write_rf, sel_xcpt;
  logic [ADDR_W-1:0]  sel_dest;
  logic [DATA_W-1:0]  sel_data;
  logic [PC_W-1:0]    sel_pc;
  logic [XADDR_W-1:0] sel_xaddr;

  always_comb begin
    grant_alu   = 1'b0;
    grant_cache = 1'b0;
    // Nothing is granted while holding or while a flush is in flight.
    if (state_q == RUN && !bus.flush) begin
      if (bus.alu_valid && (!bus.cache_valid || rr_q == RR_ALU)) grant_alu = 1'b1;
      else if (bus.cache_valid)                                  grant_cache = 1'b1;
    end
    accept = grant_alu | grant_cache;

    sel_write_rf = grant_cache ? bus.cache_write_rf  : bus.alu_write_rf;
    sel_xcpt     = grant_cache ? bus.cache_xcpt      : bus.alu_xcpt;
    sel_dest     = grant_cache ? bus.cache_dest      : bus.alu_dest;
    sel_data     = grant_cache ? bus.cache_data      : bus.alu_data;
    sel_pc       = grant_cache ? bus.cache_pc        : bus.alu_pc;
    sel_xaddr    = grant_cache ? bus.cache_xcpt_addr : bus.alu_xcpt_addr;

    state_d  = state_q;
    rr_d     = rr_q;
    we_d     = 1'b0;
    dest_d   = dest_q;
    data_d   = data_q;
    xv_d     = 1'b0;
    rmpc_d   = rmpc_q;
    rmaddr_d = rmaddr_q;

    if (grant_alu)   rr_d = RR_CACHE;
    if (grant_cache) rr_d = RR_ALU;

    if (accept && sel_xcpt) begin
      xv_d     = 1'b1;
      rmpc_d   = sel_pc;
      rmaddr_d = sel_xaddr;
      state_d  = HOLD;
    end else if (accept && sel_write_rf) begin
      we_d   = 1'b1;
      dest_d = sel_dest;
      data_d = sel_data;
    end

    if (state_q == HOLD && bus.flush) state_d = RUN;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= RUN;
      rr_q     <= RR_ALU;
      we_q     <= 1'b0;
      dest_q   <= '0;
      data_q   <= '0;
      xv_q     <= 1'b0;
      rmpc_q   <= '0;
      rmaddr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      we_q     <= we_d;
      dest_q   <= dest_d;
      data_q   <= data_d;
      xv_q     <= xv_d;
      rmpc_q   <= rmpc_d;
      rmaddr_q <= rmaddr_d;
    end
  end

  assign bus.alu_ready         = grant_alu;
  assign bus.cache_ready       = grant_cache;
  assign bus.req_to_RF_writeEn = we_q;
  assign bus.req_to_RF_dest    = dest_q;
  assign bus.req_to_RF_data    = data_q;
  assign bus.xcpt_valid        = xv_q;
  assign bus.rmPC              = rmpc_q;
  assign bus.rmAddr            = rmaddr_q;
  assign bus.xcpt_hold         = (state_q == HOLD);
endmodule

// File: tb/tb_wb_rf_arbiter.sv
// Directed bench for wb_rf_arbiter: hand-computed expectations for grant order, RF write,
// exception report/hold, flush and reset behaviour.
module tb_wb_rf_arbiter;
  logic clock;
  logic reset;
  int unsigned n_checks;
  int unsigned n_errors;

  wb_rf_arbiter_if #(.DATA_W(32), .ADDR_W(5), .PC_W(32), .XADDR_W(32)) bus ();

  wb_rf_arbiter #(.DATA_W(32), .ADDR_W(5), .PC_W(32), .XADDR_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_alu(input logic v, input logic wr, input logic x, input logic [4:0] d,
                         input logic [31:0] dat, input logic [31:0] pc, input logic [31:0] xa);
    bus.alu_valid = v; bus.alu_write_rf = wr; bus.alu_xcpt = x; bus.alu_dest = d;
    bus.alu_data = dat; bus.alu_pc = pc; bus.alu_xcpt_addr = xa;
  endtask

  task automatic set_cache(input logic v, input logic wr, input logic x, input logic [4:0] d,
                           input logic [31:0] dat, input logic [31:0] pc, input logic [31:0] xa);
    bus.cache_valid = v; bus.cache_write_rf = wr; bus.cache_xcpt = x; bus.cache_dest = d;
    bus.cache_data = dat; bus.cache_pc = pc; bus.cache_xcpt_addr = xa;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] d, input logic [31:0] dat);
    chk({tag, "_we"},   64'(bus.req_to_RF_writeEn), 64'(we));
    chk({tag, "_dest"}, 64'(bus.req_to_RF_dest),    64'(d));
    chk({tag, "_data"}, 64'(bus.req_to_RF_data),    64'(dat));
  endtask

  task automatic chk_rdy(input string tag, input logic a, input logic c);
    chk({tag, "_alu_rdy"},   64'(bus.alu_ready),   64'(a));
    chk({tag, "_cache_rdy"}, 64'(bus.cache_ready), 64'(c));
  endtask

  task automatic chk_x(input string tag, input logic xv, input logic [31:0] pc,
                       input logic [31:0] xa, input logic hold);
    chk({tag, "_xv"},   64'(bus.xcpt_valid), 64'(xv));
    chk({tag, "_pc"},   64'(bus.rmPC),       64'(pc));
    chk({tag, "_addr"}, 64'(bus.rmAddr),     64'(xa));
    chk({tag, "_hold"}, 64'(bus.xcpt_hold),  64'(hold));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.flush = 1'b0;
    set_alu(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    set_cache(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    chk_rf("rst", 0, 5'd0, 32'h0);
    chk_x("rst", 0, 32'h0, 32'h0, 0);

    // 1: single ALU request
    reset = 1'b1;
    set_alu(1, 1, 0, 5'd3, 32'hAA, 32'h0, 32'h0);
    #1 chk_rdy("t1", 1, 0);
    tick();
    set_alu(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    chk_rf("t1", 1, 5'd3, 32'hAA);

    // 2: both valid from a fresh reset -> ALU, cache, ALU, cache
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_alu(1, 1, 0, 5'd1, 32'h11, 32'h0, 32'h0);
    set_cache(1, 1, 0, 5'd2, 32'h22, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1 chk_rdy($sformatf("t2_%0d", i), (i % 2) == 0, (i % 2) == 1);
      tick();
      if ((i % 2) == 0) chk_rf($sformatf("t2_%0d", i), 1, 5'd1, 32'h11);
      else              chk_rf($sformatf("t2_%0d", i), 1, 5'd2, 32'h22);
    end
    set_alu(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);

    // 3: cache exception -> report, hold, flush, resume (rr points at ALU)
    set_cache(1, 1, 1, 5'd7, 32'h77, 32'h100, 32'h2000);
    #1 chk_rdy("t3a", 0, 1);
    tick();
    set_cache(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    set_alu(1, 1, 0, 5'd4, 32'h44, 32'h0, 32'h0);
    chk_rf("t3a", 0, 5'd2, 32'h22);
    chk_x("t3a", 1, 32'h100, 32'h2000, 1);
    #1 chk_rdy("t3b", 0, 0);
    tick();
    chk_rf("t3b", 0, 5'd2, 32'h22);
    chk_x("t3b", 0, 32'h100, 32'h2000, 1);
    bus.flush = 1'b1;
    #1 chk_rdy("t3c", 0, 0);
    tick();
    bus.flush = 1'b0;
    chk_x("t3c", 0, 32'h100, 32'h2000, 0);
    #1 chk_rdy("t3d", 1, 0);
    tick();
    chk_rf("t3d", 1, 5'd4, 32'h44);

    // 4: ALU accept without RF write; rr then favours cache
    set_alu(1, 0, 0, 5'd9, 32'h99, 32'h0, 32'h0);
    #1 chk_rdy("t4a", 1, 0);
    tick();
    chk_rf("t4a", 0, 5'd4, 32'h44);
    set_alu(1, 1, 0, 5'd5, 32'h55, 32'h0, 32'h0);
    set_cache(1, 1, 0, 5'd6, 32'h66, 32'h0, 32'h0);
    #1 chk_rdy("t4b", 0, 1);

    // 5: flush in RUN blocks grants, no state change, rr unchanged
    bus.flush = 1'b1;
    #1 chk_rdy("t5a", 0, 0);
    tick();
    bus.flush = 1'b0;
    chk_rf("t5a", 0, 5'd4, 32'h44);
    chk_x("t5a", 0, 32'h100, 32'h2000, 0);
    #1 chk_rdy("t5b", 0, 1);
    tick();
    chk_rf("t5b", 1, 5'd6, 32'h66);

    // 6: both with exception, ALU wins; reset while holding
    set_alu(1, 1, 1, 5'd5, 32'h55, 32'h300, 32'h4000);
    set_cache(1, 1, 1, 5'd6, 32'h66, 32'h500, 32'h6000);
    #1 chk_rdy("t6a", 1, 0);
    tick();
    set_alu(0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    chk_x("t6a", 1, 32'h300, 32'h4000, 1);
    #1 chk_rdy("t6b", 0, 0);
    tick();
    chk_x("t6b", 0, 32'h300, 32'h4000, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_rf("t6c", 0, 5'd0, 32'h0);
    chk_x("t6c", 0, 32'h0, 32'h0, 0);
    set_alu(1, 1, 0, 5'd8, 32'h88, 32'h0, 32'h0);
    set_cache(1, 1, 0, 5'd6, 32'h66, 32'h0, 32'h0);
    #1 chk_rdy("t6d", 1, 0);
    tick();
    chk_rf("t6d", 1, 5'd8, 32'h88);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
